// File: rtl/con_ff_logic_pkg.sv
// Shared constants for the CON flip-flop block: C2 condition encodings and
// the position of the C2 field inside the instruction register.
package con_ff_logic_pkg;

  localparam logic [1:0] C2_BRZR = 2'b00;
  localparam logic [1:0] C2_BRNZ = 2'b01;
  localparam logic [1:0] C2_BRPL = 2'b10;
  localparam logic [1:0] C2_BRMI = 2'b11;

  localparam int C2_MSB = 20;
  localparam int C2_LSB = 19;

endpackage : con_ff_logic_pkg

// File: rtl/con_ff_logic_decoder_2to4.sv
// 2-to-4 one-hot decoder used to select which branch test applies.
module decoder_2to4 (
  input  logic [1:0] sel,
  output logic [3:0] dec
);

  always_comb begin
    dec      = 4'b0000;
    dec[sel] = 1'b1;
  end

endmodule : decoder_2to4

// File: rtl/con_ff_logic.sv
// CON flip-flop: evaluates the IR C2 branch condition against the bus and
// registers the result; the control unit sees it zero-extended to 32 bits.
module con_ff_logic
  import con_ff_logic_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] IRIn,
  input  logic [31:0] BusMuxIn,
  output logic [31:0] ControlUnitOut
);

  logic [1:0] c2;
  logic [3:0] c2_dec;
  logic       bus_zero;
  logic       cond;
  logic       con;
  logic       unused_ir;

  assign c2 = IRIn[C2_MSB:C2_LSB];

  // Only the C2 field matters; fold the rest so it is visibly consumed.
  assign unused_ir = ^{IRIn[31:C2_MSB+1], IRIn[C2_LSB-1:0]};

  decoder_2to4 u_decoder_2to4 (
    .sel (c2),
    .dec (c2_dec)
  );

  assign bus_zero = ~|BusMuxIn;

  assign cond = (c2_dec[C2_BRZR] &  bus_zero)
              | (c2_dec[C2_BRNZ] & ~bus_zero)
              | (c2_dec[C2_BRPL] & ~BusMuxIn[31])
              | (c2_dec[C2_BRMI] &  BusMuxIn[31]);

  always_ff @(posedge clk) begin
    if (!clear) begin
      con <= 1'b0;
    end else if (enable) begin
      con <= cond;
    end
  end

  assign ControlUnitOut = {31'b0, con};

endmodule : con_ff_logic

// File: tb/tb_con_ff_logic.sv
// Directed self-checking bench for con_ff_logic using hand-computed vectors.
module tb_con_ff_logic;

  logic        clk;
  logic        clear;
  logic        enable;
  logic [31:0] IRIn;
  logic [31:0] BusMuxIn;
  logic [31:0] ControlUnitOut;

  int errors = 0;
  int checks = 0;

  con_ff_logic dut (
    .clk            (clk),
    .clear          (clear),
    .enable         (enable),
    .IRIn           (IRIn),
    .BusMuxIn       (BusMuxIn),
    .ControlUnitOut (ControlUnitOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs away from the edge, take one rising edge, sample 1 ns later.
  task automatic step(input logic clr, input logic en, input logic [31:0] ir,
                      input logic [31:0] bus);
    clear    = clr;
    enable   = en;
    IRIn     = ir;
    BusMuxIn = bus;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (ControlUnitOut === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, ControlUnitOut, expected);
    end
  endtask

  initial begin
    clear    = 1'b0;
    enable   = 1'b0;
    IRIn     = '0;
    BusMuxIn = '0;
    #2;

    // Reset beats enable even when the condition is true.
    step(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000); check("reset_over_enable", 32'h0);

    // brzr
    step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000); check("brzr_zero", 32'h1);
    step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0005); check("brzr_nonzero", 32'h0);

    // brnz
    step(1'b1, 1'b1, 32'h0008_0000, 32'h0000_0001); check("brnz_one", 32'h1);
    step(1'b1, 1'b1, 32'h0008_0000, 32'h0000_0000); check("brnz_zero", 32'h0);
    step(1'b1, 1'b1, 32'h0008_0000, 32'h8000_0000); check("brnz_msb_only", 32'h1);

    // brpl
    step(1'b1, 1'b1, 32'h0010_0000, 32'h7FFF_FFFF); check("brpl_maxpos", 32'h1);
    step(1'b1, 1'b1, 32'h0010_0000, 32'h8000_0000); check("brpl_neg", 32'h0);
    step(1'b1, 1'b1, 32'h0010_0000, 32'h0000_0000); check("brpl_zero", 32'h1);

    // brmi
    step(1'b1, 1'b1, 32'h0018_0000, 32'h8000_0000); check("brmi_neg", 32'h1);
    step(1'b1, 1'b1, 32'h0018_0000, 32'h0000_0003); check("brmi_pos", 32'h0);
    step(1'b1, 1'b1, 32'h0018_0000, 32'hFFFF_FFFF); check("brmi_allones", 32'h1);

    // Hold: enable low, condition false for three edges.
    step(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0005); check("hold_1", 32'h1);
    step(1'b1, 1'b0, 32'h0008_0000, 32'h0000_0000); check("hold_2", 32'h1);
    step(1'b1, 1'b0, 32'h0018_0000, 32'h0000_0003); check("hold_3", 32'h1);

    // Unused IR bits set, C2 = 00.
    step(1'b1, 1'b1, 32'hFFE7_FFFF, 32'h0000_0000); check("ir_unused_bits_zero", 32'h1);
    step(1'b1, 1'b1, 32'hFFE7_FFFF, 32'h0000_0001); check("ir_unused_bits_nonzero", 32'h0);

    // No combinational path: change inputs to a true condition between edges.
    enable   = 1'b1;
    IRIn     = 32'h0000_0000;
    BusMuxIn = 32'h0000_0000;
    #2;
    check("no_comb_path", 32'h0);

    // Mid-operation reset clears a stored 1, with and without enable.
    step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000); check("set_before_reset", 32'h1);
    step(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000); check("reset_mid_op", 32'h0);
    step(1'b1, 1'b1, 32'h0018_0000, 32'h8000_0000); check("recover_after_reset", 32'h1);
    step(1'b0, 1'b1, 32'h0018_0000, 32'h8000_0000); check("reset_priority_true", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_con_ff_logic
